pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 40 ++++
 rtl/ras_stack.sv | 72 +++++++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the program-counter sequencer:
//   - PC_select encodings SEL_INC .. SEL_HOLD
//   - pc_mode_e, the decoded next-PC mode
//   - decode_sel(), which folds both HOLD encodings (6 and 7) into MODE_HOLD
package pc_seq_pkg;

  localparam logic [2:0] SEL_INC    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_CALL   = 3'd3;
  localparam logic [2:0] SEL_RETURN = 3'd4;
  localparam logic [2:0] SEL_REGJMP = 3'd5;
  localparam logic [2:0] SEL_HOLD   = 3'd6;

  typedef enum logic [2:0] {
    MODE_INC    = 3'd0,
    MODE_BRANCH = 3'd1,
    MODE_JUMP   = 3'd2,
    MODE_CALL   = 3'd3,
    MODE_RETURN = 3'd4,
    MODE_REGJMP = 3'd5,
    MODE_HOLD   = 3'd6
  } pc_mode_e;

  function automatic pc_mode_e decode_sel(input logic [2:0] sel);
    pc_mode_e mode;
    case (sel)
      SEL_INC:    mode = MODE_INC;
      SEL_BRANCH: mode = MODE_BRANCH;
      SEL_JUMP:   mode = MODE_JUMP;
      SEL_CALL:   mode = MODE_CALL;
      SEL_RETURN: mode = MODE_RETURN;
      SEL_REGJMP: mode = MODE_REGJMP;
      default:    mode = MODE_HOLD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack
// Circular return-address stack. When full, a push overwrites the oldest
// entry, so later pops return the newest RAS_DEPTH pushes.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   push        write push_data on top of the stack
//   pop         discard the top entry (ignored when empty)
//   push_data   address to push
//   data        current top-of-stack entry
//   count       number of valid entries, 0..RAS_DEPTH
//   full        count == RAS_DEPTH
//   empty       count == 0
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              data,
  output logic [$clog2(RAS_DEPTH):0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     count_q, count_d;

  assign full  = (count_q == CW'(RAS_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // ptr_q always names the next slot to write; the top entry sits just
  // below it. Wrapping the pointer is what makes overflow drop the oldest.
  assign data = mem_q[ptr_q - PW'(1)];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program-counter sequencer with a return-address stack.
// Ports:
//   Clock, Reset      rising-edge clock, asynchronous active-high reset
//   PC_enable         advance the PC this cycle
//   PC_select         next-PC mode (INC/BRANCH/JUMP/CALL/RETURN/REGJMP/HOLD)
//   BranchOff         signed relative offset for BRANCH
//   JumpTarget        absolute target for JUMP and CALL
//   RA                register-supplied target for REGJMP
//   DebugLoad/Addr    debug PC load; takes priority over PC_enable
//   ClearFlags        clears the sticky RAS flags
//   PC, PC_temp       current PC and the PC before the last update
//   RasCount          valid RAS entries
//   RasOverflow/Underflow  sticky RAS error flags
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(1)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       PC_enable,
  input  logic [2:0]                 PC_select,
  input  logic [ADDR_W-1:0]          BranchOff,
  input  logic [ADDR_W-1:0]          JumpTarget,
  input  logic [ADDR_W-1:0]          RA,
  input  logic                       DebugLoad,
  input  logic [ADDR_W-1:0]          DebugAddr,
  input  logic                       ClearFlags,
  output logic [ADDR_W-1:0]          PC,
  output logic [ADDR_W-1:0]          PC_temp,
  output logic [$clog2(RAS_DEPTH):0] RasCount,
  output logic                       RasOverflow,
  output logic                       RasUnderflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_temp_q, pc_temp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] pc_inc;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clock),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .data      (ras_top),
    .count     (RasCount),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc_inc = pc_q + ADDR_W'(1);

  // Flags are cleared first so that a setting event in the same cycle
  // still leaves the flag at 1.
  always_comb begin
    pc_d      = pc_q;
    pc_temp_d = pc_temp_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ovf_d     = ClearFlags ? 1'b0 : ovf_q;
    unf_d     = ClearFlags ? 1'b0 : unf_q;

    if (DebugLoad) begin
      pc_d      = DebugAddr;
      pc_temp_d = pc_q;
    end else if (PC_enable) begin
      pc_temp_d = pc_q;
      case (decode_sel(PC_select))
        MODE_INC:    pc_d = pc_inc;
        MODE_BRANCH: pc_d = pc_q + BranchOff;
        MODE_JUMP:   pc_d = JumpTarget;
        MODE_CALL: begin
          pc_d     = JumpTarget;
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
        end
        MODE_RETURN: begin
          if (ras_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        MODE_REGJMP: pc_d = RA;
        default:     pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q      <= RESET_ADDR;
      pc_temp_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_temp_q <= pc_temp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign PC           = pc_q;
  assign PC_temp      = pc_temp_q;
  assign RasOverflow  = ovf_q;
  assign RasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer (default parameters). A queue-based
// reference model tracks PC, PC_temp, the return-address stack and the
// sticky flags; every falling edge compares the DUT against it, and
// hand-computed literals pin the model at key points.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        PC_enable = 1'b0;
  logic [2:0]  PC_select = SEL_INC;
  logic [31:0] BranchOff = '0;
  logic [31:0] JumpTarget = '0;
  logic [31:0] RA = '0;
  logic        DebugLoad = 1'b0;
  logic [31:0] DebugAddr = '0;
  logic        ClearFlags = 1'b0;
  logic [31:0] PC, PC_temp;
  logic [3:0]  RasCount;
  logic        RasOverflow, RasUnderflow;

  int errors = 0;
  int checks = 0;
  bit compare_on = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_pc_temp, m_old;
  logic [31:0] m_stack[$];
  logic        m_ovf, m_unf;

  pc_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .PC_enable    (PC_enable),
    .PC_select    (PC_select),
    .BranchOff    (BranchOff),
    .JumpTarget   (JumpTarget),
    .RA           (RA),
    .DebugLoad    (DebugLoad),
    .DebugAddr    (DebugAddr),
    .ClearFlags   (ClearFlags),
    .PC           (PC),
    .PC_temp      (PC_temp),
    .RasCount     (RasCount),
    .RasOverflow  (RasOverflow),
    .RasUnderflow (RasUnderflow)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs at a falling edge, return at the next one.
  task automatic applyStimulus(input logic en, input logic [2:0] sel,
                               input logic [31:0] boff, input logic [31:0] jt,
                               input logic [31:0] ra, input logic dl,
                               input logic [31:0] da, input logic cf);
    PC_enable  = en;
    PC_select  = sel;
    BranchOff  = boff;
    JumpTarget = jt;
    RA         = ra;
    DebugLoad  = dl;
    DebugAddr  = da;
    ClearFlags = cf;
    @(negedge Clock);
  endtask

  // Reference model: the sequencer's rules expressed with a plain queue.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_pc = 32'd1;
      m_pc_temp = '0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_old = m_pc;
      if (ClearFlags) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (DebugLoad) begin
        m_pc_temp = m_old;
        m_pc = DebugAddr;
      end else if (PC_enable) begin
        m_pc_temp = m_old;
        case (PC_select)
          3'd0: m_pc = m_old + 32'd1;
          3'd1: m_pc = m_old + BranchOff;
          3'd2: m_pc = JumpTarget;
          3'd3: begin
            if (m_stack.size() == DEPTH) begin
              void'(m_stack.pop_front());
              m_ovf = 1'b1;
            end
            m_stack.push_back(m_old + 32'd1);
            m_pc = JumpTarget;
          end
          3'd4: begin
            if (m_stack.size() == 0) begin
              m_pc = m_old + 32'd1;
              m_unf = 1'b1;
            end else begin
              m_pc = m_stack.pop_back();
            end
          end
          3'd5: m_pc = RA;
          default: m_pc = m_old;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge Clock) begin
    if (compare_on) begin
      checkOutput("model_pc", PC, m_pc);
      checkOutput("model_pc_temp", PC_temp, m_pc_temp);
      checkOutput("model_ras_count", 32'(RasCount), 32'(m_stack.size()));
      checkOutput("model_ovf", 32'(RasOverflow), 32'(m_ovf));
      checkOutput("model_unf", 32'(RasUnderflow), 32'(m_unf));
    end
  end

  initial begin
    repeat (2) @(negedge Clock);
    checkOutput("reset_pc", PC, 32'd1);
    checkOutput("reset_pc_temp", PC_temp, 32'd0);
    checkOutput("reset_count", 32'(RasCount), 32'd0);
    checkOutput("reset_flags", {30'd0, RasOverflow, RasUnderflow}, 32'd0);
    Reset = 1'b0;
    compare_on = 1'b1;

    // four increments: PC 1 -> 5, PC_temp trailing
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, SEL_INC, 0, 0, 0, 0, 0, 0);
      checkOutput("inc_pc", PC, 32'(i + 2));
      checkOutput("inc_pc_temp", PC_temp, 32'(i + 1));
    end

    // disabled cycles hold everything
    applyStimulus(0, SEL_JUMP, 0, 32'h55, 0, 0, 0, 0);
    checkOutput("hold_disabled_pc", PC, 32'd5);

    // branch backwards
    applyStimulus(0, SEL_INC, 0, 0, 0, 1, 32'd10, 0);
    checkOutput("debug_pc_temp", PC_temp, 32'd5);
    applyStimulus(1, SEL_BRANCH, -32'sd3, 0, 0, 0, 0, 0);
    checkOutput("branch_neg_pc", PC, 32'd7);
    applyStimulus(1, SEL_BRANCH, 32'd100, 0, 0, 0, 0, 0);
    checkOutput("branch_pos_pc", PC, 32'd107);

    // increment wraps
    applyStimulus(0, SEL_INC, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus(1, SEL_INC, 0, 0, 0, 0, 0, 0);
    checkOutput("inc_wrap_pc", PC, 32'd0);

    // call and return
    applyStimulus(0, SEL_INC, 0, 0, 0, 1, 32'd5, 0);
    applyStimulus(1, SEL_CALL, 0, 32'h40, 0, 0, 0, 0);
    checkOutput("call_pc", PC, 32'h40);
    checkOutput("call_count", 32'(RasCount), 32'd1);
    applyStimulus(1, SEL_RETURN, 0, 0, 0, 0, 0, 0);
    checkOutput("ret_pc", PC, 32'd6);
    checkOutput("ret_count", 32'(RasCount), 32'd0);

    // jump, register jump, both hold encodings
    applyStimulus(1, SEL_JUMP, 0, 32'h100, 0, 0, 0, 0);
    applyStimulus(1, SEL_REGJMP, 0, 0, 32'h200, 0, 0, 0);
    checkOutput("regjmp_pc", PC, 32'h200);
    applyStimulus(1, SEL_HOLD, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3'd7, 0, 0, 0, 0, 0, 0);
    checkOutput("hold7_pc", PC, 32'h200);
    checkOutput("hold7_pc_temp", PC_temp, 32'h200);

    // overflow: nine calls from PC 0 push 1..9, the 1 is overwritten
    applyStimulus(0, SEL_INC, 0, 0, 0, 1, 32'd0, 0);
    for (int i = 1; i <= 9; i++)
      applyStimulus(1, SEL_CALL, 0, 32'(i), 0, 0, 0, 0);
    checkOutput("ovf_flag", 32'(RasOverflow), 32'd1);
    checkOutput("ovf_count", 32'(RasCount), 32'd8);
    for (int i = 9; i >= 2; i--) begin
      applyStimulus(1, SEL_RETURN, 0, 0, 0, 0, 0, 0);
      checkOutput("lifo_pop_pc", PC, 32'(i));
    end
    applyStimulus(1, SEL_RETURN, 0, 0, 0, 0, 0, 0);
    checkOutput("underflow_pc", PC, 32'd3);
    checkOutput("underflow_flag", 32'(RasUnderflow), 32'd1);

    // clear racing a new underflow: underflow wins, overflow clears
    applyStimulus(1, SEL_RETURN, 0, 0, 0, 0, 0, 1);
    checkOutput("clear_race_unf", 32'(RasUnderflow), 32'd1);
    checkOutput("clear_race_ovf", 32'(RasOverflow), 32'd0);
    applyStimulus(0, SEL_INC, 0, 0, 0, 0, 0, 1);
    checkOutput("clear_unf", 32'(RasUnderflow), 32'd0);

    // debug load overrides an enabled call
    applyStimulus(1, SEL_CALL, 0, 32'h30, 0, 0, 0, 0);
    applyStimulus(1, SEL_CALL, 0, 32'h99, 0, 1, 32'h7F, 0);
    checkOutput("debug_pc", PC, 32'h7F);
    checkOutput("debug_count", 32'(RasCount), 32'd1);

    // asynchronous reset in the middle of a call
    PC_enable = 1'b1;
    PC_select = SEL_CALL;
    JumpTarget = 32'h123;
    DebugLoad = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_reset_pc", PC, 32'd1);
    checkOutput("async_reset_count", 32'(RasCount), 32'd0);
    checkOutput("async_reset_pc_temp", PC_temp, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    applyStimulus(1, SEL_INC, 0, 0, 0, 0, 0, 0);
    checkOutput("post_reset_inc_pc", PC, 32'd2);
    applyStimulus(0, SEL_INC, 0, 0, 0, 0, 0, 0);

    compare_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
